// File: rtl/pip_hazard_ctrl.sv
// pip_hazard_ctrl: stall/bubble controller for the 5-stage MIPS pipeline.
// Detects Tuse/Tnew data hazards and holds HI/LO instructions in D
// while the mult/div unit is busy. It drives the PC and inter-stage
// register enables, plus the D/E bubble clear.
// Inputs:  D sources and Tuse, E/M destinations and Tnew, mult/div launch.
// Outputs: pc_en, fd_en, de_clr, em_en, mw_en, stall, md_busy.
// Optional: PIP_HAZARD_STATS_EN adds stall_cnt and md_stall_cnt
// (saturating 32-bit stall counters).
module pip_hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic [1:0]  d_tuse_rs,
    input  logic [1:0]  d_tuse_rt,
    input  logic        d_md,
    input  logic [4:0]  e_wa,
    input  logic [1:0]  e_tnew,
    input  logic        e_md_start,
    input  logic        e_md_div,
    input  logic [4:0]  m_wa,
    input  logic [1:0]  m_tnew,
    output logic        pc_en,
    output logic        fd_en,
    output logic        de_clr,
    output logic        em_en,
    output logic        mw_en,
    output logic        stall,
`ifdef PIP_HAZARD_STATS_EN
    output logic [31:0] stall_cnt,
    output logic [31:0] md_stall_cnt,
`endif
    output logic        md_busy
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hz_rs, hz_rt, md_stall;

    // Tuse of 3 marks an unused source; $0 is never a real dependency.
    always_comb begin
        hz_rs = (d_tuse_rs != 2'd3) && (d_rs != 5'd0) &&
                (((d_rs == e_wa) && (e_tnew > d_tuse_rs)) ||
                 ((d_rs == m_wa) && (m_tnew > d_tuse_rs)));
        hz_rt = (d_tuse_rt != 2'd3) && (d_rt != 5'd0) &&
                (((d_rt == e_wa) && (e_tnew > d_tuse_rt)) ||
                 ((d_rt == m_wa) && (m_tnew > d_tuse_rt)));
    end

    // The start cycle itself counts as busy, so the counter is loaded
    // with N-1 and the launch pulse covers the first cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (e_md_start) begin
            cnt_d = e_md_div ? CNT_W'(DIV_CYCLES - 1)
                             : CNT_W'(MULT_CYCLES - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    // md_busy is forced low by reset so it drops with the async clear.
    always_comb begin
        md_busy  = !reset && (e_md_start || (cnt_q != '0));
        md_stall = d_md && md_busy;
        stall    = hz_rs || hz_rt || md_stall;
        pc_en    = !stall;
        fd_en    = !stall;
        de_clr   = stall;
        em_en    = 1'b1;
        mw_en    = 1'b1;
    end

`ifdef PIP_HAZARD_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] md_stall_cnt_q, md_stall_cnt_d;

    always_comb begin
        stall_cnt_d    = stall_cnt_q;
        md_stall_cnt_d = md_stall_cnt_q;
        if (stall && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 32'd1;
        if (md_stall && (md_stall_cnt_q != '1))
            md_stall_cnt_d = md_stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q    <= '0;
            md_stall_cnt_q <= '0;
        end else begin
            stall_cnt_q    <= stall_cnt_d;
            md_stall_cnt_q <= md_stall_cnt_d;
        end
    end

    assign stall_cnt    = stall_cnt_q;
    assign md_stall_cnt = md_stall_cnt_q;
`endif

endmodule

// File: tb/tb_pip_hazard_ctrl.sv
// tb_pip_hazard_ctrl: directed-vector self-checking bench for
// pip_hazard_ctrl (hazards, mult/div busy, reset, optional counters).
module tb_pip_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] d_rs, d_rt, e_wa, m_wa;
    logic [1:0] d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
    logic       d_md, e_md_start, e_md_div;
    logic       pc_en, fd_en, de_clr, em_en, mw_en, stall, md_busy;
`ifdef PIP_HAZARD_STATS_EN
    logic [31:0] stall_cnt, md_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pip_hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .d_rs(d_rs), .d_rt(d_rt),
        .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_md(d_md), .e_wa(e_wa), .e_tnew(e_tnew),
        .e_md_start(e_md_start), .e_md_div(e_md_div),
        .m_wa(m_wa), .m_tnew(m_tnew),
        .pc_en(pc_en), .fd_en(fd_en), .de_clr(de_clr),
        .em_en(em_en), .mw_en(mw_en), .stall(stall),
`ifdef PIP_HAZARD_STATS_EN
        .stall_cnt(stall_cnt), .md_stall_cnt(md_stall_cnt),
`endif
        .md_busy(md_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        d_rs = 0; d_rt = 0; d_tuse_rs = 3; d_tuse_rt = 3; d_md = 0;
        e_wa = 0; e_tnew = 0; e_md_start = 0; e_md_div = 0;
        m_wa = 0; m_tnew = 0;
    endtask

    task automatic chk_stall(input string tag, input logic exp);
        #1;
        chk({tag, "_stall"}, 32'(stall), 32'(exp));
        chk({tag, "_pc_en"}, 32'(pc_en), 32'(!exp));
        chk({tag, "_fd_en"}, 32'(fd_en), 32'(!exp));
        chk({tag, "_de_clr"}, 32'(de_clr), 32'(exp));
    endtask

    initial begin
        idle();
        reset = 1'b1;
        #2;
        chk_stall("rst", 1'b0);
        chk("rst_em_en", 32'(em_en), 1);
        chk("rst_mw_en", 32'(mw_en), 1);
        chk("rst_busy", 32'(md_busy), 0);
        cyc();
        reset = 1'b0;

        // Load-use: lw $8 in E, addu uses $8 in E stage.
        cyc(); idle();
        d_rs = 8; d_tuse_rs = 1; e_wa = 8; e_tnew = 2;
        chk_stall("lu1", 1'b1);
        cyc(); idle();
        d_rs = 8; d_tuse_rs = 1; m_wa = 8; m_tnew = 1;
        chk_stall("lu2", 1'b0);

        // Branch compare in D.
        cyc(); idle();
        d_rs = 8; d_tuse_rs = 0; e_wa = 8; e_tnew = 1;
        chk_stall("br1", 1'b1);
        cyc(); idle();
        d_rs = 8; d_tuse_rs = 0; m_wa = 8; m_tnew = 0;
        chk_stall("br2", 1'b0);
        cyc(); idle();
        d_rs = 0; d_tuse_rs = 0; e_wa = 0; e_tnew = 1;
        chk_stall("br_r0", 1'b0);
        cyc(); idle();
        d_rs = 8; d_tuse_rs = 0; m_wa = 8; m_tnew = 1;
        chk_stall("br_m", 1'b1);

        // Dual match on rs and rt.
        cyc(); idle();
        d_rs = 9; d_rt = 9; e_wa = 9; e_tnew = 1;
        d_tuse_rs = 0; d_tuse_rt = 1;
        chk_stall("dual1", 1'b1);
        d_tuse_rs = 3;
        chk_stall("dual2", 1'b0);
        d_tuse_rt = 0;
        chk_stall("rt_only", 1'b1);

        // Busy unit without a HI/LO instruction in D: no stall.
        cyc(); idle();
        e_md_start = 1;
        #1;
        chk("nomd_busy", 32'(md_busy), 1);
        chk_stall("nomd", 1'b0);
        cyc(); idle();

        // Reset clears everything, including stats.
        reset = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        chk("rst2_busy", 32'(md_busy), 0);
`ifdef PIP_HAZARD_STATS_EN
        chk("rst_scnt", stall_cnt, 0);
        chk("rst_mcnt", md_stall_cnt, 0);
`endif

        // Divide: busy and mflo stall for 10 cycles from the start.
        cyc(); idle();
        for (int i = 0; i <= 10; i++) begin
            d_md = 1;
            e_md_start = (i == 0);
            e_md_div = (i == 0);
            #1;
            chk($sformatf("div_busy%0d", i), 32'(md_busy),
                32'(i < 10));
            chk($sformatf("div_stall%0d", i), 32'(stall),
                32'(i < 10));
            if (i < 10) cyc();
        end
`ifdef PIP_HAZARD_STATS_EN
        chk("div_scnt", stall_cnt, 10);
        chk("div_mcnt", md_stall_cnt, 10);
`endif

        // Multiply: 5 busy cycles.
        cyc(); idle();
        for (int i = 0; i <= 5; i++) begin
            d_md = 1;
            e_md_start = (i == 0);
            #1;
            chk($sformatf("mul_busy%0d", i), 32'(md_busy),
                32'(i < 5));
            chk($sformatf("mul_stall%0d", i), 32'(stall),
                32'(i < 5));
            if (i < 5) cyc();
        end

        // Reset mid-countdown.
        cyc(); idle();
        d_md = 1; e_md_start = 1;
        cyc();
        e_md_start = 0;
        cyc();
        #1;
        chk("mid_busy_pre", 32'(md_busy), 1);
        reset = 1'b1;
        #1;
        chk("mid_busy", 32'(md_busy), 0);
        chk("mid_stall", 32'(stall), 0);
        cyc();
        reset = 1'b0;
        cyc();
        #1;
        chk("post_busy", 32'(md_busy), 0);
        chk("post_stall", 32'(stall), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pip_hazard_ctrl.md
Name: pip_hazard_ctrl

Overview:
Central stall/bubble controller for the 5-stage MIPS pipeline (F/D/E/M/W).
- Drives the enable and clear inputs of every inter-stage pipeline register (F/D, D/E, E/M, M/W) and the PC.
- Detects data hazards with a Tuse/Tnew comparison.
- Tracks the multi-cycle mult/div unit with a busy countdown so that HI/LO-class instructions are held in D while the unit is busy.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu, counting the start cycle; must be >= 1.
DIV_CYCLES, 10, busy cycles for div/divu, counting the start cycle; must be >= 1.
CNT_W, 4, countdown width; must hold max(MULT_CYCLES, DIV_CYCLES)-1.

Ports:
clk  in  1  pipeline clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high; clears all state immediately.
d_rs  in  5  rs address of the instruction in D.
d_rt  in  5  rt address of the instruction in D.
d_tuse_rs  in  2  stages until D needs rs: 0=D, 1=E, 2=M; 3 = not used.
d_tuse_rt  in  2  same encoding as d_tuse_rs, for rt.
d_md  in  1  instruction in D is mult/div/mfhi/mflo/mthi/mtlo.
e_wa  in  5  destination register of the E instruction; 0 = none.
e_tnew  in  2  cycles until the E result is forwardable.
e_md_start  in  1  E instruction launches the mult/div unit this cycle.
e_md_div  in  1  the launch is a div/divu; qualifies e_md_start.
m_wa  in  5  destination register of the M instruction.
m_tnew  in  2  cycles until the M result is forwardable.
pc_en  out  1  PC register enable.
fd_en  out  1  F/D register enable.
de_clr  out  1  synchronous clear of the D/E register (bubble insert).
em_en  out  1  E/M register enable.
mw_en  out  1  M/W register enable.
stall  out  1  D stage stalled this cycle.
md_busy  out  1  mult/div unit busy.

Behaviour:
Hazard match, per source s in {rs, rt}:
- hz_s = (d_tuse_s != 3) & (d_s != 0) & ((d_s == e_wa & e_tnew > d_tuse_s) | (d_s == m_wa & m_tnew > d_tuse_s)).
- A source that matches both e_wa and m_wa is judged against each stage independently (OR).

Mult/div countdown:
- On e_md_start, cnt <= (e_md_div ? DIV_CYCLES : MULT_CYCLES) - 1.
- Otherwise, if cnt != 0, cnt <= cnt - 1.
- md_busy = e_md_start | (cnt != 0). Busy is asserted for exactly N consecutive cycles, starting with the start cycle.
- md_stall = d_md & md_busy.

Stall outputs:
- stall = hz_rs | hz_rt | md_stall. This is combinational from the current inputs and cnt.
- While stall: pc_en = 0, fd_en = 0, de_clr = 1.
- While not stall: pc_en = 1, fd_en = 1, de_clr = 0.
- em_en and mw_en are tied to 1 (E, M and W always drain).

Boundary conditions:
- e_md_start while cnt != 0 reloads the counter (the newest launch wins). Decode never produces this case, because a d_md instruction stalls behind a busy unit.
- A bubble in E presents e_wa = 0 and e_md_start = 0, so it never causes a hazard.
- Writes to $0 never cause a hazard.
- Reset, asserted at any time including mid-countdown: cnt = 0 and md_busy = 0 immediately.
- After reset, with zero inputs: stall = 0, pc_en = fd_en = em_en = mw_en = 1, de_clr = 0.
- A delayed branch in D is never flushed; the delay slot always executes. This block generates no F/D clear.

Optional Feature:
Macro: PIP_HAZARD_STATS_EN.

When defined:
- Adds output stall_cnt (32 bits).
- stall_cnt increments on every clock edge where stall = 1 and saturates at 0xFFFFFFFF.
- Adds output md_stall_cnt (32 bits), with the same rule applied to md_stall.
- Both counters are cleared asynchronously by reset.

When undefined:
- The ports and counters do not exist.
- All other behaviour is identical.

Test Plan:
1. Load-use. E: lw $8, e_wa = 8, e_tnew = 2. D: addu using rs = 8, tuse 1.
   - Cycle 1: stall = 1, pc_en = fd_en = 0, de_clr = 1.
   - Next cycle, same D with m_wa = 8, m_tnew = 1: stall = 0.
2. Branch compare. D: beq, rs = 8, tuse 0. E: addu, e_wa = 8, e_tnew = 1.
   - One stall cycle.
   - Then with M: m_wa = 8, m_tnew = 0: stall = 0.
   - Repeat with rs = 0: stall = 0 throughout.
3. Divide. e_md_start = 1, e_md_div = 1 at cycle T, followed by mflo in D.
   - md_busy = 1 for cycles T..T+9.
   - stall = 1 for cycles T..T+9, stall = 0 at T+10.
   - Multiply: same check with busy lasting 5 cycles.
4. Reset mid-countdown. Start mult, assert reset at cycle 2 (between clock edges).
   - md_busy = 0 and stall = 0 immediately.
   - Counter stays 0 after reset is released.
5. Dual match. rs = rt = 9, e_wa = 9, e_tnew = 1, tuse_rs = 0, tuse_rt = 1.
   - stall = 1 (driven by rs only).
   - With tuse_rs = 3: stall = 0.
6. With PIP_HAZARD_STATS_EN. Run scenario 3 (div).
   - stall_cnt = 10 and md_stall_cnt = 10.
   - Both counters = 0 after reset.
